// File: rtl/clk_sched.sv
// Rate controller for the FSM clock divider: owns the divide ratio, runs/stops/single-steps
// the divided clock, and swaps in new ratios only on period boundaries.
module clk_sched #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] DEFAULT_SCALE = WIDTH'(24)
) (
  input  logic             CCLK,
  input  logic             RST,
  input  logic             run,
  input  logic             step,
  input  logic [WIDTH-1:0] scale_in,
  input  logic             scale_valid,
  output logic             scale_ready,
  output logic             tick,
  output logic             clk,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] scale_cur
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           st;
  state_t           st_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;
  logic             pend_vld;
  logic             rearm;
  logic             boundary;
  logic             accept;
  logic             apply;

  // Equality compare: cnt never wraps, so the all-ones scale is legal.
  assign boundary = (st != ST_STOP) && (cnt == scale_cur);
  assign accept   = scale_valid && scale_ready;
  assign apply    = pend_vld && ((st == ST_STOP) || boundary);
  assign state    = st;

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      st <= ST_STOP;
    end else begin
      st <= st_nxt;
    end
  end

  // Stops and steps only leave on a boundary, so no period is ever truncated.
  always_comb begin
    st_nxt = st;
    case (st)
      ST_STOP: begin
        if (run) begin
          st_nxt = ST_RUN;
        end else if (step) begin
          st_nxt = ST_STEP;
        end
      end
      ST_RUN: begin
        if (boundary && !run) begin
          st_nxt = ST_STOP;
        end
      end
      ST_STEP: begin
        if (boundary) begin
          st_nxt = run ? ST_RUN : ST_STOP;
        end
      end
      default: st_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      tick <= 1'b0;
      clk  <= 1'b0;
    end else if (st == ST_STOP) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (boundary) begin
      cnt  <= '0;
      tick <= 1'b1;
      clk  <= ~clk;
    end else begin
      cnt  <= cnt + WIDTH'(1);
      tick <= 1'b0;
    end
  end

  // Ready stays low from transfer until one edge after the value is applied,
  // so accept and apply can never coincide.
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      pend_vld    <= 1'b0;
      rearm       <= 1'b0;
      scale_ready <= 1'b1;
      scale_cur   <= DEFAULT_SCALE;
    end else begin
      rearm <= apply;
      if (apply) begin
        scale_cur <= pend;
        pend_vld  <= 1'b0;
      end else if (accept) begin
        pend_vld  <= 1'b1;
      end
      if (accept) begin
        scale_ready <= 1'b0;
      end else if (rearm) begin
        scale_ready <= 1'b1;
      end
    end
  end

  always_ff @(posedge CCLK) begin
    if (accept) begin
      pend <= scale_in;
    end
  end

endmodule

// File: tb/tb_clk_sched.sv
// Directed bench for clk_sched: run/stop/step timing, boundary-aligned scale changes, async reset.
module tb_clk_sched;

  logic        CCLK = 1'b0;
  logic        RST;
  logic        run;
  logic        step;
  logic [31:0] scale_in;
  logic        scale_valid;
  logic        scale_ready;
  logic        tick;
  logic        clk;
  logic [1:0]  state;
  logic [31:0] scale_cur;

  int tests = 0;
  int fails = 0;

  clk_sched #(.WIDTH(32), .DEFAULT_SCALE(32'd24)) dut (
    .CCLK(CCLK), .RST(RST), .run(run), .step(step),
    .scale_in(scale_in), .scale_valid(scale_valid), .scale_ready(scale_ready),
    .tick(tick), .clk(clk), .state(state), .scale_cur(scale_cur)
  );

  always #5 CCLK = ~CCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge CCLK);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) edge1();
  endtask

  // Returns the number of edges until tick is seen high (capped at 200).
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      edge1();
      n++;
    end while (!tick && n < 200);
  endtask

  task automatic set_scale_stop(input logic [31:0] v, input logic [31:0] prev);
    scale_in    = v;
    scale_valid = 1'b1;
    edge1();
    chk("hs_ready_drop", {31'd0, scale_ready}, 32'd0);
    chk("hs_not_yet", scale_cur, prev);
    scale_valid = 1'b0;
    edge1();
    chk("hs_applied", scale_cur, v);
    chk("hs_ready_low", {31'd0, scale_ready}, 32'd0);
    edge1();
    chk("hs_ready_back", {31'd0, scale_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int cnt_ticks;
    RST = 1'b1; run = 1'b0; step = 1'b0; scale_in = '0; scale_valid = 1'b0;
    adv(2);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_clk", {31'd0, clk}, 32'd0);
    chk("rst_scale", scale_cur, 32'd24);
    chk("rst_ready", {31'd0, scale_ready}, 32'd1);
    RST = 1'b0;
    edge1();

    // Default scale 24: tick every 25 cycles
    run = 1'b1;
    edge1();
    chk("t1_state_run", {30'd0, state}, 32'd1);
    wait_tick(n);
    chk("t1_first_tick", n, 32'd25);
    chk("t1_clk_1", {31'd0, clk}, 32'd1);
    edge1();
    chk("t1_tick_pulse", {31'd0, tick}, 32'd0);
    wait_tick(n);
    chk("t1_second_tick", n, 32'd24);
    chk("t1_clk_2", {31'd0, clk}, 32'd0);
    run = 1'b0;
    wait_tick(n);
    chk("t1_stop_tick", n, 32'd25);
    chk("t1_stop_state", {30'd0, state}, 32'd0);

    // Scale 3, stop two cycles after a tick
    set_scale_stop(32'd3, 32'd24);
    run = 1'b1;
    edge1();
    chk("t2_state_run", {30'd0, state}, 32'd1);
    wait_tick(n);
    chk("t2_first_tick", n, 32'd4);
    wait_tick(n);
    chk("t2_second_tick", n, 32'd4);
    chk("t2_clk", {31'd0, clk}, 32'd1);
    adv(2);
    run = 1'b0;
    wait_tick(n);
    chk("t2_final_tick", n, 32'd2);
    chk("t2_final_state", {30'd0, state}, 32'd0);
    chk("t2_final_clk", {31'd0, clk}, 32'd0);
    cnt_ticks = 0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      if (tick) cnt_ticks++;
    end
    chk("t2_no_ticks", cnt_ticks, 32'd0);
    chk("t2_clk_hold", {31'd0, clk}, 32'd0);

    // Single steps with scale 4
    set_scale_stop(32'd4, 32'd3);
    step = 1'b1;
    edge1();
    step = 1'b0;
    chk("t3_state_step", {30'd0, state}, 32'd2);
    wait_tick(n);
    chk("t3_step1_tick", n, 32'd5);
    chk("t3_step1_state", {30'd0, state}, 32'd0);
    chk("t3_step1_clk", {31'd0, clk}, 32'd1);
    cnt_ticks = 0;
    for (int i = 0; i < 94; i++) begin
      edge1();
      if (tick) cnt_ticks++;
    end
    chk("t3_idle_ticks", cnt_ticks, 32'd0);
    step = 1'b1;
    edge1();
    step = 1'b0;
    chk("t3_state_step2", {30'd0, state}, 32'd2);
    wait_tick(n);
    chk("t3_step2_tick", n, 32'd5);
    chk("t3_step2_state", {30'd0, state}, 32'd0);
    chk("t3_step2_clk", {31'd0, clk}, 32'd0);

    // Scale change 9 -> 1 in the middle of a RUN period
    set_scale_stop(32'd9, 32'd4);
    run = 1'b1;
    edge1();
    wait_tick(n);
    chk("t4_first_tick", n, 32'd10);
    adv(3);
    scale_in = 32'd1;
    scale_valid = 1'b1;
    edge1();
    scale_valid = 1'b0;
    chk("t4_ready_drop", {31'd0, scale_ready}, 32'd0);
    chk("t4_scale_old", scale_cur, 32'd9);
    wait_tick(n);
    chk("t4_period_done", n, 32'd6);
    chk("t4_scale_new", scale_cur, 32'd1);
    chk("t4_ready_still_low", {31'd0, scale_ready}, 32'd0);
    edge1();
    chk("t4_ready_back", {31'd0, scale_ready}, 32'd1);
    wait_tick(n);
    chk("t4_fast_tick1", n, 32'd1);
    wait_tick(n);
    chk("t4_fast_tick2", n, 32'd2);
    chk("t4_clk", {31'd0, clk}, 32'd0);
    run = 1'b0;
    wait_tick(n);
    chk("t4_stop_tick", n, 32'd2);
    chk("t4_stop_state", {30'd0, state}, 32'd0);

    // Scale 0 with run and step on the same edge
    set_scale_stop(32'd0, 32'd1);
    run = 1'b1;
    step = 1'b1;
    edge1();
    step = 1'b0;
    chk("t5_run_priority", {30'd0, state}, 32'd1);
    chk("t5_no_tick_yet", {31'd0, tick}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      edge1();
      chk("t5_tick_every", {31'd0, tick}, 32'd1);
      chk("t5_clk_toggle", {31'd0, clk}, (i % 2 == 0) ? 32'd0 : 32'd1);
    end
    run = 1'b0;
    wait_tick(n);
    chk("t5_stop_tick", n, 32'd1);
    chk("t5_stop_state", {30'd0, state}, 32'd0);

    // Reset mid-period with a scale pending
    set_scale_stop(32'd9, 32'd0);
    run = 1'b1;
    edge1();
    wait_tick(n);
    chk("t6_first_tick", n, 32'd10);
    adv(3);
    scale_in = 32'd5;
    scale_valid = 1'b1;
    edge1();
    scale_valid = 1'b0;
    chk("t6_pending", {31'd0, scale_ready}, 32'd0);
    edge1();
    chk("t6_clk_pre", {31'd0, clk}, 32'd1);
    chk("t6_state_pre", {30'd0, state}, 32'd1);
    #2;
    RST = 1'b1;
    run = 1'b0;
    #1;
    chk("t6_async_state", {30'd0, state}, 32'd0);
    chk("t6_async_clk", {31'd0, clk}, 32'd0);
    chk("t6_async_tick", {31'd0, tick}, 32'd0);
    chk("t6_async_scale", scale_cur, 32'd24);
    chk("t6_async_ready", {31'd0, scale_ready}, 32'd1);
    edge1();
    RST = 1'b0;
    adv(3);
    chk("t6_scale_kept", scale_cur, 32'd24);
    chk("t6_ready_after", {31'd0, scale_ready}, 32'd1);
    chk("t6_state_after", {30'd0, state}, 32'd0);
    run = 1'b1;
    edge1();
    wait_tick(n);
    chk("t6_default_tick", n, 32'd25);
    run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
